// File: rtl/rv_instr_encoder_if.sv
// Field-level instruction beat channel from the program-load source to the encoder.
interface rv_instr_encoder_if;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_class;
  logic [3:0]         in_control;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic signed [31:0] in_imm;
  logic               in_last;

  modport master (
    output in_valid, in_class, in_control, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_control, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: packs field-level beats into 32-bit words and writes
// them to consecutive IMEM words through a registered write port.
module rv_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  rv_instr_encoder_if.slave   in_if,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERROR} state_t;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] word;
  } enc_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  function automatic logic [2:0] alu_f3(input logic [3:0] ctl);
    case (ctl)
      4'd2:       alu_f3 = 3'b111;
      4'd3:       alu_f3 = 3'b110;
      4'd4:       alu_f3 = 3'b100;
      4'd5:       alu_f3 = 3'b001;
      4'd6, 4'd7: alu_f3 = 3'b101;
      4'd8:       alu_f3 = 3'b011;
      4'd9:       alu_f3 = 3'b010;
      default:    alu_f3 = 3'b000;
    endcase
  endfunction

  // BEQ/BNE map to 000/001, the remaining four conditions sit at 100..111.
  function automatic logic [2:0] br_f3(input logic [3:0] ctl);
    br_f3 = (ctl < 4'd2) ? {2'b00, ctl[0]} : (ctl[2:0] + 3'd2);
  endfunction

  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits(input logic signed [31:0] v, input int bits);
    logic signed [31:0] t;
    t = v >>> (bits - 1);
    fits = (t == '0) || (t == '1);
  endfunction

  function automatic enc_t encode(input logic [2:0] cls, input logic [3:0] ctl,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic signed [31:0] imm);
    enc_t e;
    e.code = 2'd0;
    e.word = '0;
    case (cls)
      3'd0: begin
        if (ctl > 4'd9) e.code = 2'd1;
        else e.word = {((ctl == 4'd1) || (ctl == 4'd7)) ? F7_ALT : 7'b0,
                       rs2, rs1, alu_f3(ctl), rd, OP_R};
      end
      3'd1: begin
        if ((ctl > 4'd9) || (ctl == 4'd1)) e.code = 2'd1;
        else if (ctl inside {4'd5, 4'd6, 4'd7}) begin
          if (imm[31:5] != '0) e.code = 2'd2;
          else e.word = {(ctl == 4'd7) ? F7_ALT : 7'b0, imm[4:0], rs1, alu_f3(ctl), rd, OP_I};
        end
        else if (!fits(imm, 12)) e.code = 2'd2;
        else e.word = {imm[11:0], rs1, alu_f3(ctl), rd, OP_I};
      end
      3'd2: begin
        if (ctl[3] || (ctl[2:0] inside {3'b011, 3'b110, 3'b111})) e.code = 2'd1;
        else if (!fits(imm, 12)) e.code = 2'd2;
        else e.word = {imm[11:0], rs1, ctl[2:0], rd, OP_LOAD};
      end
      3'd3: begin
        if (ctl > 4'd2) e.code = 2'd1;
        else if (!fits(imm, 12)) e.code = 2'd2;
        else e.word = {imm[11:5], rs2, rs1, ctl[2:0], imm[4:0], OP_STORE};
      end
      3'd4: begin
        if (ctl > 4'd5) e.code = 2'd1;
        else if (!fits(imm, 13) || imm[0]) e.code = 2'd2;
        else e.word = {imm[12], imm[10:5], rs2, rs1, br_f3(ctl), imm[4:1], imm[11], OP_BRANCH};
      end
      3'd5: begin
        if (!fits(imm, 21) || imm[0]) e.code = 2'd2;
        else e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      3'd6: begin
        if (!fits(imm, 12)) e.code = 2'd2;
        else e.word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      default: e.code = 2'd1;
    endcase
    return e;
  endfunction

  state_t              state_q, state_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                in_ready_w;
  logic                accept;
  enc_t                enc;

  assign in_ready_w     = (state_q == S_LOAD) && !start;
  assign accept         = in_if.in_valid && in_ready_w;
  assign in_if.in_ready = in_ready_w;

  always_comb begin
    enc          = encode(in_if.in_class, in_if.in_control, in_if.in_rd,
                          in_if.in_rs1, in_if.in_rs2, in_if.in_imm);
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    count_d      = count_q;
    if (start) begin
      state_d    = S_LOAD;
      count_d    = '0;
      err_d      = 1'b0;
      err_code_d = 2'd0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (enc.code != 2'd0) begin
              state_d    = S_ERROR;
              err_d      = 1'b1;
              err_code_d = enc.code;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = BASE + count_q[ADDR_W-1:0];
              imem_wdata_d = enc.word;
              count_d      = count_q + 1'b1;
              if (in_if.in_last) state_d = S_DRAIN;
              else if (count_q == LAST_CNT) begin
                // Capacity exhausted with more program to come: keep the word, flag overflow.
                state_d    = S_ERROR;
                err_d      = 1'b1;
                err_code_d = 2'd3;
              end
            end
          end
        end
        S_DRAIN: begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      count_q      <= count_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign count      = count_q;

endmodule
